// File: rtl/commit_free_list.sv
// commit_free_list: retirement RAT plus circular free list feeding rename with physical registers.
// Optional build macro COMMIT_FREE_LIST_RECOVERY_EN adds a flush input that rewinds head to committed_head.
module commit_free_list #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int PHYS_REGS      = 64,
    parameter int ARCH_REGS      = 32,
    localparam int FL_DEPTH      = PHYS_REGS - ARCH_REGS,
    localparam int PTR_W         = $clog2(FL_DEPTH),
    localparam int CNT_W         = $clog2(FL_DEPTH + 1),
    localparam int PT_W          = 8,
    localparam int AT_W          = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DISPATCH_WIDTH-1:0]            commit_en,
    input  logic [DISPATCH_WIDTH-1:0][PT_W-1:0]  commit_phys_rd,
    input  logic [DISPATCH_WIDTH-1:0][AT_W-1:0]  commit_arch_rd,
    input  logic [DISPATCH_WIDTH-1:0]            alloc_req,
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
    input  logic                                 flush,
`endif
    output logic                                 alloc_ready,
    output logic [DISPATCH_WIDTH-1:0][PT_W-1:0]  alloc_phys,
    output logic [CNT_W-1:0]                     free_count,
    output logic                                 err_overflow
);

    logic [FL_DEPTH-1:0][PT_W-1:0]  fl_q, fl_d, fl_init;
    logic [ARCH_REGS-1:0][PT_W-1:0] rrat_q, rrat_d, rrat_init;
    logic [PTR_W-1:0]               head_q, head_d;
    logic [PTR_W-1:0]               tail_q, tail_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           err_q, err_d;
    logic [CNT_W-1:0]               n_pop;
    logic [CNT_W-1:0]               n_push;
    logic [CNT_W:0]                 occ;
    logic                           flush_i;

`ifdef COMMIT_FREE_LIST_RECOVERY_EN
    logic [PTR_W-1:0]               chead_q, chead_d;
    logic [CNT_W-1:0]               n_act;
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < FL_DEPTH; i++) fl_init[i] = PT_W'(ARCH_REGS + i);
        for (int i = 0; i < ARCH_REGS; i++) rrat_init[i] = PT_W'(i);
    end

    // Lane w reads the slot after all lower requesting lanes; a pop only happens when ready.
    always_comb begin
        logic [CNT_W-1:0] n_req;
        n_req       = '0;
        alloc_ready = (count_q >= CNT_W'(DISPATCH_WIDTH)) && !flush_i;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            alloc_phys[w] = fl_q[head_q + PTR_W'(n_req)];
            n_req         = n_req + CNT_W'(alloc_req[w]);
        end
        n_pop = alloc_ready ? n_req : '0;
    end

    // Reading rrat_d inside the loop forwards lower-lane writes to the same arch reg.
    always_comb begin
        fl_d   = fl_q;
        rrat_d = rrat_q;
        err_d  = err_q;
        n_push = '0;
        occ    = {1'b0, count_q} - {1'b0, n_pop};
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
        n_act  = '0;
`endif
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            if (commit_en[w] && (commit_arch_rd[w] != '0)) begin
                if ((occ + {1'b0, n_push}) >= (CNT_W+1)'(FL_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    fl_d[tail_q + PTR_W'(n_push)] = rrat_d[commit_arch_rd[w]];
                    n_push = n_push + CNT_W'(1);
                end
                rrat_d[commit_arch_rd[w]] = commit_phys_rd[w];
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
                n_act = n_act + CNT_W'(1);
`endif
            end
        end
        head_d  = head_q + PTR_W'(n_pop);
        tail_d  = tail_q + PTR_W'(n_push);
        count_d = count_q + n_push - n_pop;
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
        chead_d = chead_q + PTR_W'(n_act);
        if (flush) begin
            head_d  = chead_d;
            count_d = CNT_W'(FL_DEPTH);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fl_q    <= fl_init;
            rrat_q  <= rrat_init;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_DEPTH);
            err_q   <= 1'b0;
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
            chead_q <= '0;
`endif
        end else begin
            fl_q    <= fl_d;
            rrat_q  <= rrat_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
            chead_q <= chead_d;
`endif
        end
    end

    assign free_count   = count_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_commit_free_list.sv
// Scoreboard bench for commit_free_list: a queue-based free-list/RAT model predicts each cycle's outputs.
module tb_commit_free_list;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       commit_en;
    logic [1:0][7:0]  commit_phys_rd;
    logic [1:0][4:0]  commit_arch_rd;
    logic [1:0]       alloc_req;
    logic             alloc_ready;
    logic [1:0][7:0]  alloc_phys;
    logic [5:0]       free_count;
    logic             err_overflow;
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
    logic             flush = 1'b0;
`endif

    commit_free_list dut (
        .clk            (clk),
        .rst            (rst),
        .commit_en      (commit_en),
        .commit_phys_rd (commit_phys_rd),
        .commit_arch_rd (commit_arch_rd),
        .alloc_req      (alloc_req),
`ifdef COMMIT_FREE_LIST_RECOVERY_EN
        .flush          (flush),
`endif
        .alloc_ready    (alloc_ready),
        .alloc_phys     (alloc_phys),
        .free_count     (free_count),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ready;
        int count;
        bit err;
        bit c0;
        bit c1;
        int p0;
        int p1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: free list as a FIFO of tags, RAT as a plain array.
    int   fl_m[$];
    int   rrat_m[32];
    bit   err_m;
    int   inflight[$];

    function automatic void chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("alloc_ready", int'(alloc_ready), int'(e.ready));
            chk("free_count", int'(free_count), e.count);
            chk("err_overflow", int'(err_overflow), int'(e.err));
            if (e.c0) chk("alloc_phys0", int'(alloc_phys[0]), e.p0);
            if (e.c1) chk("alloc_phys1", int'(alloc_phys[1]), e.p1);
        end
    end

    task automatic model_reset();
        fl_m.delete();
        inflight.delete();
        for (int i = 32; i < 64; i++) fl_m.push_back(i);
        for (int i = 0; i < 32; i++) rrat_m[i] = i;
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        commit_en      = 2'($urandom);
        commit_phys_rd = 16'($urandom);
        commit_arch_rd = 10'($urandom);
        alloc_req      = 2'($urandom);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input bit [1:0] en, input int pr0, input int ar0,
                         input int pr1, input int ar1, input bit [1:0] req);
        exp_t e;
        int   pr[2];
        int   ar[2];
        pr[0] = pr0; pr[1] = pr1; ar[0] = ar0; ar[1] = ar1;
        commit_en         = en;
        commit_phys_rd[0] = 8'(pr0);
        commit_phys_rd[1] = 8'(pr1);
        commit_arch_rd[0] = 5'(ar0);
        commit_arch_rd[1] = 5'(ar1);
        alloc_req         = req;
        e.count = fl_m.size();
        e.ready = (fl_m.size() >= 2);
        e.err   = err_m;
        e.c0    = e.ready && req[0];
        e.c1    = e.ready && req[1];
        e.p0    = e.c0 ? fl_m[0] : 0;
        e.p1    = e.c1 ? fl_m[req[0] ? 1 : 0] : 0;
        exp_q.push_back(e);
        if (e.ready) begin
            if (req[0]) inflight.push_back(fl_m.pop_front());
            if (req[1]) inflight.push_back(fl_m.pop_front());
        end
        for (int l = 0; l < 2; l++) begin
            if (en[l] && ar[l] != 0) begin
                if (fl_m.size() < 32) fl_m.push_back(rrat_m[ar[l]]);
                else err_m = 1'b1;
                rrat_m[ar[l]] = pr[l];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pr[2];
        int ar[2];
        bit [1:0] en;
        do_reset();

        // Reset state plus first dual allocation, then a single lane-1 allocation.
        drive(2'b00, 0, 0, 0, 0, 2'b11);
        drive(2'b00, 0, 0, 0, 0, 2'b10);
        // Commit arch 5 -> frees phys 5; then two same-arch commits in one cycle.
        drive(2'b01, 32, 5, 0, 0, 2'b00);
        drive(2'b11, 40, 7, 41, 7, 2'b00);
        // Drain with arch-0 commits; list wraps past the freed regs.
        while (fl_m.size() >= 3) drive(2'b11, 0, 0, 0, 0, 2'b11);
        if (fl_m.size() == 2) drive(2'b11, 0, 0, 0, 0, 2'b01);
        repeat (4) drive(2'b11, 0, 0, 0, 0, 2'($urandom_range(1, 3)));
        drive(2'b00, 0, 0, 0, 0, 2'b00);

        // Randomized rounds with recycling of granted tags.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                en = 2'b00;
                for (int l = 0; l < 2; l++) begin
                    pr[l] = 0;
                    ar[l] = 0;
                    if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
                        en[l] = 1'b1;
                        pr[l] = inflight.pop_front();
                        if ($urandom_range(0, 31) == 0) pr[l] = $urandom_range(0, 63);
                        ar[l] = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 31);
                    end
                end
                drive(en, pr[0], ar[0], pr[1], ar[1], 2'($urandom));
            end
        end

        // Overflow: a push into a full list is dropped and sets the sticky flag.
        do_reset();
        drive(2'b01, 9, 3, 0, 0, 2'b00);
        drive(2'b11, 10, 4, 11, 6, 2'b00);
        drive(2'b00, 0, 0, 0, 0, 2'b11);
        do_reset();
        drive(2'b00, 0, 0, 0, 0, 2'b00);

`ifdef COMMIT_FREE_LIST_RECOVERY_EN
        begin
            exp_t e;
            do_reset();
            drive(2'b00, 0, 0, 0, 0, 2'b11);
            drive(2'b00, 0, 0, 0, 0, 2'b11);
            drive(2'b01, 32, 1, 0, 0, 2'b00);
            flush     = 1'b1;
            commit_en = 2'b00;
            alloc_req = 2'b11;
            e = '{ready: 1'b0, count: 29, err: 1'b0, c0: 1'b0, c1: 1'b0, p0: 0, p1: 0};
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            flush     = 1'b0;
            alloc_req = 2'b01;
            e = '{ready: 1'b1, count: 32, err: 1'b0, c0: 1'b1, c1: 1'b0, p0: 33, p1: 0};
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            do_reset();
        end
`endif

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
